trig_led_sequencer: RTL and testbench

- Upstream controller for the trigger-LED output stage.
- Holds a small table of (delay, duration) entries.
- On start, plays the entries in order, looping a programmable number of times, by driving the output stage's reset, onYourMark, GOGOGO_EXCLAMATION, delay and duration, then waiting on its trigLedComplete.
- Sits between the host register interface and the trigger-LED output stage.

---
 rtl/trig_led_sequencer.sv | 165 ++++++++++++++++
 tb/tb_trig_led_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_led_sequencer.sv
// rtl/trig_led_sequencer.sv - plays a (delay, duration) table into the trigger-LED output stage
// Optional inter-entry gap state enabled by TRIG_SEQ_GAP_EN.
module trig_led_sequencer #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int DUR_W  = 11,
   parameter int DEL_W  = 21
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hardStop,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DEL_W-1:0]  wr_delay,
   input  logic [DUR_W-1:0]  wr_duration,
   input  logic [ADDR_W:0]   seq_len,
   input  logic [15:0]       loop_count,
`ifdef TRIG_SEQ_GAP_EN
   input  logic [15:0]       gap_cycles,
`endif
   input  logic              start,
   input  logic              trigLedComplete,
   output logic              trig_rst,
   output logic              onYourMark,
   output logic              GOGOGO_EXCLAMATION,
   output logic [DEL_W-1:0]  delay,
   output logic [DUR_W-1:0]  duration,
   output logic              busy,
   output logic [ADDR_W-1:0] cur_index,
   output logic              seq_done,
   output logic              seq_aborted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARM,
      S_FIRE,
      S_WAIT,
`ifdef TRIG_SEQ_GAP_EN
      S_GAP,
`endif
      S_NEXT
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   state_t            state;
   logic [DEL_W-1:0]  tbl_delay    [DEPTH];
   logic [DUR_W-1:0]  tbl_duration [DEPTH];
   logic [ADDR_W:0]   len_q;
   logic [15:0]       loops_q;
   logic [15:0]       pass_q;
   logic              last_entry;
   logic              last_pass;
`ifdef TRIG_SEQ_GAP_EN
   logic [15:0]       gap_q;
   logic [15:0]       gap_cnt;
`endif

   assign last_entry = ({1'b0, cur_index} == (len_q - 1'b1));
   assign last_pass  = ((pass_q + 16'd1) == loops_q);

   // Table is frozen while a sequence runs so every pass sees the same entries.
   always_ff @(posedge clk) begin
      if (wr_en && state == S_IDLE) begin
         tbl_delay[wr_addr]    <= wr_delay;
         tbl_duration[wr_addr] <= wr_duration;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= S_IDLE;
         trig_rst           <= 1'b1;
         onYourMark         <= 1'b0;
         GOGOGO_EXCLAMATION <= 1'b0;
         delay              <= '0;
         duration           <= '0;
         busy               <= 1'b0;
         cur_index          <= '0;
         seq_done           <= 1'b0;
         seq_aborted        <= 1'b0;
      end else if (hardStop) begin
         state              <= S_IDLE;
         trig_rst           <= 1'b1;
         onYourMark         <= 1'b0;
         GOGOGO_EXCLAMATION <= 1'b0;
         busy               <= 1'b0;
         seq_done           <= 1'b0;
         seq_aborted        <= (state != S_IDLE);
      end else begin
         seq_done    <= 1'b0;
         seq_aborted <= 1'b0;
         case (state)
            S_IDLE: begin
               trig_rst           <= 1'b1;
               onYourMark         <= 1'b0;
               GOGOGO_EXCLAMATION <= 1'b0;
               if (start && seq_len != '0) begin
                  len_q     <= (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
                  loops_q   <= (loop_count == 16'd0) ? 16'd1 : loop_count;
                  cur_index <= '0;
                  pass_q    <= 16'd0;
`ifdef TRIG_SEQ_GAP_EN
                  gap_q     <= gap_cycles;
`endif
                  busy      <= 1'b1;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               delay      <= tbl_delay[cur_index];
               duration   <= tbl_duration[cur_index];
               trig_rst   <= 1'b0;
               onYourMark <= 1'b1;
               state      <= S_ARM;
            end
            S_ARM: begin
               GOGOGO_EXCLAMATION <= 1'b1;
               state              <= S_FIRE;
            end
            S_FIRE: begin
               onYourMark         <= 1'b0;
               GOGOGO_EXCLAMATION <= 1'b0;
               state              <= S_WAIT;
            end
            S_WAIT: begin
               if (trigLedComplete) begin
                  trig_rst <= 1'b1;
                  state    <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (last_entry) begin
                  cur_index <= '0;
                  pass_q    <= pass_q + 16'd1;
               end else begin
                  cur_index <= cur_index + 1'b1;
               end
               if (last_entry && last_pass) begin
                  busy     <= 1'b0;
                  seq_done <= 1'b1;
                  state    <= S_IDLE;
               end else begin
`ifdef TRIG_SEQ_GAP_EN
                  gap_cnt <= gap_q;
                  state   <= (gap_q != 16'd0) ? S_GAP : S_LOAD;
`else
                  state   <= S_LOAD;
`endif
               end
            end
`ifdef TRIG_SEQ_GAP_EN
            S_GAP: begin
               if (gap_cnt == 16'd1) state <= S_LOAD;
               else gap_cnt <= gap_cnt - 16'd1;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trig_led_sequencer.sv
// tb/tb_trig_led_sequencer.sv - scoreboard bench for trig_led_sequencer with a behavioural output stage
// Build with TRIG_SEQ_GAP_EN defined to exercise the gap state.
module tb_trig_led_sequencer;

   localparam int K_FIRE = 0, K_DONE = 1, K_ABORT = 2;

   typedef struct {
      int kind;
      int idx;
      int dly;
      int dur;
      int run;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, hardStop, wr_en, start;
   logic [3:0]  wr_addr;
   logic [20:0] wr_delay;
   logic [10:0] wr_duration;
   logic [4:0]  seq_len;
   logic [15:0] loop_count;
   logic [15:0] gap_cycles;
   logic        trigLedComplete;
   logic        trig_rst, onYourMark, GOGOGO_EXCLAMATION, busy, seq_done, seq_aborted;
   logic [20:0] delay;
   logic [10:0] duration;
   logic [3:0]  cur_index;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_del[16];
   int   m_dur[16];
   int   run = 0, last_run = 0, led_cycles = 0;

   int   stg_ph = 0;
   int   stg_cnt = 0;
   logic led;

   always #5 clk = ~clk;

   trig_led_sequencer dut (
      .clk(clk), .rst(rst), .hardStop(hardStop), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_delay(wr_delay), .wr_duration(wr_duration), .seq_len(seq_len),
      .loop_count(loop_count),
`ifdef TRIG_SEQ_GAP_EN
      .gap_cycles(gap_cycles),
`endif
      .start(start), .trigLedComplete(trigLedComplete), .trig_rst(trig_rst),
      .onYourMark(onYourMark), .GOGOGO_EXCLAMATION(GOGOGO_EXCLAMATION), .delay(delay),
      .duration(duration), .busy(busy), .cur_index(cur_index), .seq_done(seq_done),
      .seq_aborted(seq_aborted)
   );

   // Behavioural output stage: delay cycles, then duration LED cycles, then complete.
   assign led = (stg_ph == 2) && (stg_cnt != 0);
   always @(posedge clk) begin
      if (rst || trig_rst) begin
         stg_ph <= 0; stg_cnt <= 0; trigLedComplete <= 1'b0;
      end else begin
         case (stg_ph)
            0: if (onYourMark && GOGOGO_EXCLAMATION) begin stg_ph <= 1; stg_cnt <= int'(delay); end
            1: if (stg_cnt == 0) begin stg_ph <= 2; stg_cnt <= int'(duration); end
               else stg_cnt <= stg_cnt - 1;
            2: if (stg_cnt == 0) begin stg_ph <= 3; trigLedComplete <= 1'b1; end
               else stg_cnt <= stg_cnt - 1;
            default: ;
         endcase
      end
   end

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT fires or pulses done/aborted.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (led) led_cycles++;
         if (busy && trig_rst) run++;
         else begin
            if (run != 0) last_run = run;
            run = 0;
         end
         if (GOGOGO_EXCLAMATION) begin
            if (sb.size() == 0) check("unexpected_fire", 1, 0);
            else begin
               e = sb.pop_front();
               check("fire_kind", K_FIRE, e.kind);
               check("fire_index", cur_index, e.idx);
               check("fire_delay", delay, e.dly);
               check("fire_duration", duration, e.dur);
               check("fire_rst_run", last_run, e.run);
               check("fire_mark", {onYourMark, trig_rst}, 2'b10);
            end
         end
         if (seq_done) begin
            if (sb.size() == 0) check("unexpected_done", 1, 0);
            else begin
               e = sb.pop_front();
               check("done_kind", K_DONE, e.kind);
               check("done_busy", busy, 0);
            end
         end
         if (seq_aborted) begin
            if (sb.size() == 0) check("unexpected_abort", 1, 0);
            else begin
               e = sb.pop_front();
               check("abort_kind", K_ABORT, e.kind);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int kind, input int idx, input int run_len);
      exp_t e;
      e.kind = kind; e.idx = idx; e.run = run_len;
      e.dly = (kind == K_FIRE) ? m_del[idx] : 0;
      e.dur = (kind == K_FIRE) ? m_dur[idx] : 0;
      sb.push_back(e);
   endtask

   task automatic push_seq(input int len, input int loops, input int gap);
      int n = (len > 16) ? 16 : len;
      int l = (loops == 0) ? 1 : loops;
      for (int p = 0; p < l; p++)
         for (int i = 0; i < n; i++)
            push(K_FIRE, i, (p == 0 && i == 0) ? 1 : 2 + gap);
      push(K_DONE, 0, 0);
   endtask

   task automatic wr(input int a, input int d, input int u, input bit accept);
      wr_en = 1'b1; wr_addr = 4'(a); wr_delay = 21'(d); wr_duration = 11'(u);
      tick();
      wr_en = 1'b0;
      if (accept) begin m_del[a] = d; m_dur[a] = u; end
   endtask

   task automatic go(input int len, input int loops, input int gap);
      push_seq(len, loops, gap);
      seq_len = 5'(len); loop_count = 16'(loops); gap_cycles = 16'(gap);
      start = 1'b1;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", busy, 0);
      tick();
   endtask

   initial begin
      int leds0;
      bit found;
      rst = 1'b1; hardStop = 1'b0; wr_en = 1'b0; start = 1'b0;
      wr_addr = '0; wr_delay = '0; wr_duration = '0;
      seq_len = '0; loop_count = '0; gap_cycles = '0;
      repeat (3) tick();
      @(negedge clk);
      check("reset_outputs", {trig_rst, onYourMark, GOGOGO_EXCLAMATION, busy, seq_done, seq_aborted}, 6'b100000);
      check("reset_delay_dur_idx", {delay, duration, cur_index}, 0);
      rst = 1'b0;
      tick();

      // Single entry with exact cycle-by-cycle handshake.
      wr(0, 2, 3, 1);
      leds0 = led_cycles;
      go(1, 1, 0);
      @(negedge clk);
      check("c1_load", {busy, trig_rst, onYourMark, GOGOGO_EXCLAMATION}, 4'b1100);
      @(negedge clk);
      check("c2_arm", {trig_rst, onYourMark, GOGOGO_EXCLAMATION}, 3'b010);
      @(negedge clk);
      check("c3_fire", {trig_rst, onYourMark, GOGOGO_EXCLAMATION}, 3'b011);
      @(negedge clk);
      check("c4_wait", {trig_rst, onYourMark, GOGOGO_EXCLAMATION}, 3'b000);
      tick();
      wait_idle(200);
      check("single_led_cycles", led_cycles - leds0, 3);
      check("single_idle_rst", trig_rst, 1);

      // Three entries, two passes.
      wr(0, 1, 1, 1); wr(1, 0, 2, 1); wr(2, 4, 1, 1);
      go(3, 2, 0);
      wait_idle(500);

      // seq_len == 0 is ignored.
      seq_len = '0; loop_count = 16'd1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("len0_busy", {busy, trig_rst}, 2'b01);
      end
      tick();

      // loop_count == 0 runs one pass.
      go(1, 0, 0);
      wait_idle(200);

      // seq_len beyond DEPTH is clamped.
      for (int i = 3; i < 16; i++) wr(i, i % 3, 1, 1);
      go(20, 1, 0);
      wait_idle(2000);

      // hardStop during WAIT of entry 1, with a start held alongside it.
      push(K_FIRE, 0, 1); push(K_FIRE, 1, 2); push(K_ABORT, 0, 0);
      seq_len = 5'd3; loop_count = 16'd1; start = 1'b1;
      tick();
      start = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clk);
         if (busy && cur_index == 4'd1 && !trig_rst && !onYourMark) found = 1'b1;
      end
      check("abort_reached_wait1", found, 1);
      hardStop = 1'b1; start = 1'b1; seq_len = 5'd1;
      tick();
      hardStop = 1'b0; start = 1'b0;
      @(negedge clk);
      check("abort_state", {busy, trig_rst, onYourMark, GOGOGO_EXCLAMATION, seq_aborted, seq_done}, 6'b010010);
      @(negedge clk);
      check("abort_after", {busy, seq_aborted}, 2'b00);
      tick();
      go(1, 1, 0);
      wait_idle(200);

      // Write while busy is dropped; write with start is used.
      go(1, 2, 0);
      tick(); tick();
      wr(0, 7, 2, 0);
      wait_idle(200);
      m_del[0] = 5; m_dur[0] = 2;
      wr_en = 1'b1; wr_addr = 4'd0; wr_delay = 21'd5; wr_duration = 11'd2;
      go(1, 1, 0);
      wait_idle(200);

`ifdef TRIG_SEQ_GAP_EN
      go(2, 1, 5);
      wait_idle(300);
`endif

      repeat (2) tick();
      check("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
